mem_rqst_scheduler: RTL and testbench

Request scheduler directly upstream of the memory controller: it accepts client read/write requests through a valid/ready port, buffers them in a FIFO and issues them one per cycle on the controller's `wr_*`/`rd_*` request pins. It tracks in-flight requests in an outstanding table tagged by address, blocks same-address hazards, and retires entries on `rd_ret_ack`/`wr_ret_ack`, delivering read data and write completions back to the client.

---
 rtl/mem_rqst_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_mem_rqst_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rqst_scheduler.sv
// mem_rqst_scheduler
//
// Request scheduler in front of the memory controller. Client requests enter
// a FIFO through a valid/ready port. The FIFO head is issued at most once per
// cycle onto the controller's wr_*/rd_* pins, and only when all of these hold:
//   - the in-flight limit is not reached;
//   - no in-flight entry carries the same address.
// Each in-flight request lives in an outstanding table tagged by its address.
// Read/write acks retire matching entries and produce a one-cycle client
// response. An ack with no matching entry of the right type sets a sticky
// tag_err.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/ready/write/address/data client request port (ready = FIFO not full)
//   wr_en/wr_address/wr_data           write issue to the controller
//   rd_en/rd_address                   read issue to the controller
//   wr_ret_ack/wr_ret_address          write completion from the controller
//   rd_ret_ack/rd_ret_address/data     read return from the controller
//   rd_rsp_valid/address/data          read response to the client
//   wr_done/wr_done_address            write completion to the client
//   outstanding                        number of in-flight requests
//   tag_err                            sticky unmatched-ack flag
module mem_rqst_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUT    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [15:0]                    req_address,
   input  logic [15:0]                    req_data,
   output logic [15:0]                    wr_address,
   output logic                           wr_en,
   output logic [15:0]                    wr_data,
   input  logic [15:0]                    wr_ret_address,
   input  logic                           wr_ret_ack,
   output logic [15:0]                    rd_address,
   output logic                           rd_en,
   input  logic [15:0]                    rd_ret_data,
   input  logic [15:0]                    rd_ret_address,
   input  logic                           rd_ret_ack,
   output logic                           rd_rsp_valid,
   output logic [15:0]                    rd_rsp_address,
   output logic [15:0]                    rd_rsp_data,
   output logic                           wr_done,
   output logic [15:0]                    wr_done_address,
   output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
   output logic                           tag_err
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
   localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Request FIFO: pointers carry one extra wrap bit to tell full from empty.
   logic             fifo_write [FIFO_DEPTH];
   logic [15:0]      fifo_addr  [FIFO_DEPTH];
   logic [15:0]      fifo_data  [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full, push;
   logic             head_write;
   logic [15:0]      head_addr, head_data;

   // Outstanding table.
   logic [MAX_OUT-1:0] tbl_valid, tbl_valid_nxt;
   logic               tbl_write [MAX_OUT];
   logic [15:0]        tbl_addr  [MAX_OUT];

   logic               hazard, free_found, rd_hit, wr_hit;
   logic [IDX_W-1:0]   free_idx, rd_idx, wr_idx;
   logic               issue, rd_free, wr_free;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready  = !fifo_full;
   assign push       = req_valid && !fifo_full;

   assign head_write = fifo_write[rd_ptr[AW-1:0]];
   assign head_addr  = fifo_addr[rd_ptr[AW-1:0]];
   assign head_data  = fifo_data[rd_ptr[AW-1:0]];

   // Table search. Descending loop so the lowest index wins for the free slot.
   // The hazard rule keeps addresses unique in the table, so at most one
   // entry can match each ack. All searches use the pre-edge valid bits:
   // a slot freed this cycle still blocks its address and cannot be reused.
   always_comb begin
      hazard     = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      rd_hit     = 1'b0;
      rd_idx     = '0;
      wr_hit     = 1'b0;
      wr_idx     = '0;
      for (int i = MAX_OUT - 1; i >= 0; i--) begin
         if (!tbl_valid[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (tbl_valid[i] && (tbl_addr[i] == head_addr))
            hazard = 1'b1;
         if (tbl_valid[i] && !tbl_write[i] && (tbl_addr[i] == rd_ret_address)) begin
            rd_hit = 1'b1;
            rd_idx = IDX_W'(i);
         end
         if (tbl_valid[i] && tbl_write[i] && (tbl_addr[i] == wr_ret_address)) begin
            wr_hit = 1'b1;
            wr_idx = IDX_W'(i);
         end
      end
   end

   assign rd_free = rd_ret_ack && rd_hit;
   assign wr_free = wr_ret_ack && wr_hit;
   assign issue   = !fifo_empty && (outstanding < MAX_CNT) && !hazard && free_found;

   always_comb begin
      tbl_valid_nxt = tbl_valid;
      if (rd_free) tbl_valid_nxt[rd_idx] = 1'b0;
      if (wr_free) tbl_valid_nxt[wr_idx] = 1'b0;
      if (issue)   tbl_valid_nxt[free_idx] = 1'b1;
   end

   // Control and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         tbl_valid       <= '0;
         outstanding     <= '0;
         wr_en           <= 1'b0;
         rd_en           <= 1'b0;
         wr_address      <= 16'h0000;
         wr_data         <= 16'h0000;
         rd_address      <= 16'h0000;
         rd_rsp_valid    <= 1'b0;
         rd_rsp_address  <= 16'h0000;
         rd_rsp_data     <= 16'h0000;
         wr_done         <= 1'b0;
         wr_done_address <= 16'h0000;
         tag_err         <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PTR_ONE;
         if (issue) rd_ptr <= rd_ptr + PTR_ONE;
         tbl_valid   <= tbl_valid_nxt;
         outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rd_free) - CNT_W'(wr_free);

         wr_en <= issue && head_write;
         rd_en <= issue && !head_write;
         if (issue && head_write) begin
            wr_address <= head_addr;
            wr_data    <= head_data;
         end
         if (issue && !head_write)
            rd_address <= head_addr;

         rd_rsp_valid <= rd_free;
         if (rd_free) begin
            rd_rsp_address <= rd_ret_address;
            rd_rsp_data    <= rd_ret_data;
         end
         wr_done <= wr_free;
         if (wr_free)
            wr_done_address <= wr_ret_address;

         if ((rd_ret_ack && !rd_hit) || (wr_ret_ack && !wr_hit))
            tag_err <= 1'b1;
      end
   end

   // Storage arrays: contents are qualified by pointers/valid bits, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr[AW-1:0]] <= req_write;
         fifo_addr[wr_ptr[AW-1:0]]  <= req_address;
         fifo_data[wr_ptr[AW-1:0]]  <= req_data;
      end
      if (issue) begin
         tbl_write[free_idx] <= head_write;
         tbl_addr[free_idx]  <= head_addr;
      end
   end

endmodule

// File: tb/tb_mem_rqst_scheduler.sv
// Testbench for mem_rqst_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based reference model.
module tb_mem_rqst_scheduler;

   localparam int FIFO_DEPTH = 4;
   localparam int MAX_OUT    = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_address, req_data;
   logic [15:0] wr_address, wr_data, wr_ret_address;
   logic        wr_en, wr_ret_ack;
   logic [15:0] rd_address, rd_ret_data, rd_ret_address;
   logic        rd_en, rd_ret_ack;
   logic        rd_rsp_valid;
   logic [15:0] rd_rsp_address, rd_rsp_data;
   logic        wr_done;
   logic [15:0] wr_done_address;
   logic [2:0]  outstanding;
   logic        tag_err;

   int checks = 0;
   int errors = 0;

   mem_rqst_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_address(req_address), .req_data(req_data),
      .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
      .rd_address(rd_address), .rd_en(rd_en),
      .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_address(rd_rsp_address), .rd_rsp_data(rd_rsp_data),
      .wr_done(wr_done), .wr_done_address(wr_done_address),
      .outstanding(outstanding), .tag_err(tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
   } req_t;

   req_t        mq[$];    // accepted, not yet issued
   req_t        inf[$];   // in flight (order irrelevant)
   logic        m_tag_err = 1'b0;
   logic        e_wr_en, e_rd_en, e_rsp, e_done;
   logic [15:0] e_wr_a, e_wr_d, e_rd_a, e_rsp_a, e_rsp_d, e_done_a;
   int          ri, wi, d1, d2, tmp;
   bit          iss, ready_pre;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         inf.delete();
         m_tag_err = 1'b0;
      end else begin
         ready_pre = (mq.size() < FIFO_DEPTH);
         ri = -1;
         wi = -1;
         foreach (inf[k]) begin
            if (!inf[k].w && inf[k].a == rd_ret_address) ri = k;
            if (inf[k].w && inf[k].a == wr_ret_address) wi = k;
         end
         iss = (mq.size() > 0) && (inf.size() < MAX_OUT);
         if (iss) foreach (inf[k]) if (inf[k].a == mq[0].a) iss = 1'b0;
         e_wr_en = iss && mq[0].w;
         e_rd_en = iss && !mq[0].w;
         e_wr_a  = iss ? mq[0].a : 16'h0;
         e_wr_d  = iss ? mq[0].d : 16'h0;
         e_rd_a  = iss ? mq[0].a : 16'h0;
         e_rsp   = rd_ret_ack && (ri >= 0);
         e_rsp_a = rd_ret_address;
         e_rsp_d = rd_ret_data;
         e_done  = wr_ret_ack && (wi >= 0);
         e_done_a = wr_ret_address;
         if ((rd_ret_ack && ri < 0) || (wr_ret_ack && wi < 0)) m_tag_err = 1'b1;
         d1 = rd_ret_ack ? ri : -1;
         d2 = wr_ret_ack ? wi : -1;
         if (d1 < d2) begin tmp = d1; d1 = d2; d2 = tmp; end
         if (d1 >= 0) inf.delete(d1);
         if (d2 >= 0) inf.delete(d2);
         if (iss) begin
            inf.push_back(mq[0]);
            void'(mq.pop_front());
         end
         if (req_valid && ready_pre) mq.push_back('{req_write, req_address, req_data});

         #1;
         chk("m_wr_en", 32'(wr_en), 32'(e_wr_en));
         chk("m_rd_en", 32'(rd_en), 32'(e_rd_en));
         if (e_wr_en) begin
            chk("m_wr_address", 32'(wr_address), 32'(e_wr_a));
            chk("m_wr_data", 32'(wr_data), 32'(e_wr_d));
         end
         if (e_rd_en) chk("m_rd_address", 32'(rd_address), 32'(e_rd_a));
         chk("m_rd_rsp_valid", 32'(rd_rsp_valid), 32'(e_rsp));
         if (e_rsp) begin
            chk("m_rd_rsp_address", 32'(rd_rsp_address), 32'(e_rsp_a));
            chk("m_rd_rsp_data", 32'(rd_rsp_data), 32'(e_rsp_d));
         end
         chk("m_wr_done", 32'(wr_done), 32'(e_done));
         if (e_done) chk("m_wr_done_address", 32'(wr_done_address), 32'(e_done_a));
         chk("m_outstanding", 32'(outstanding), 32'(inf.size()));
         chk("m_tag_err", 32'(tag_err), 32'(m_tag_err));
         chk("m_req_ready", 32'(req_ready), 32'(mq.size() < FIFO_DEPTH));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid  = 1'b0;
      rd_ret_ack = 1'b0;
      wr_ret_ack = 1'b0;
   endtask

   task automatic drive_req(input logic w, input logic [15:0] a, input logic [15:0] d);
      req_valid   = 1'b1;
      req_write   = w;
      req_address = a;
      req_data    = d;
   endtask

   task automatic chk_all_clear(input string tagname);
      chk({tagname, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tagname, "_rd_en"}, 32'(rd_en), 32'd0);
      chk({tagname, "_rd_rsp_valid"}, 32'(rd_rsp_valid), 32'd0);
      chk({tagname, "_wr_done"}, 32'(wr_done), 32'd0);
      chk({tagname, "_tag_err"}, 32'(tag_err), 32'd0);
      chk({tagname, "_outstanding"}, 32'(outstanding), 32'd0);
      chk({tagname, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tagname, "_wr_address"}, 32'(wr_address), 32'd0);
      chk({tagname, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tagname, "_rd_address"}, 32'(rd_address), 32'd0);
      chk({tagname, "_rd_rsp_address"}, 32'(rd_rsp_address), 32'd0);
      chk({tagname, "_rd_rsp_data"}, 32'(rd_rsp_data), 32'd0);
      chk({tagname, "_wr_done_address"}, 32'(wr_done_address), 32'd0);
   endtask

   initial begin
      int cnt;
      int acc;
      int k;
      rst_n = 1'b0;
      idle();
      req_write = 1'b0; req_address = '0; req_data = '0;
      wr_ret_address = '0; rd_ret_address = '0; rd_ret_data = '0;
      repeat (2) @(negedge clk);
      chk_all_clear("reset");
      rst_n = 1'b1;
      tick();

      // Basic write then read to the same address.
      drive_req(1'b1, 16'h0010, 16'hBEEF);
      tick();                                   // write accepted
      drive_req(1'b0, 16'h0010, 16'h0000);
      chk("basic_wr_en_early", 32'(wr_en), 32'd0);
      tick();                                   // write issued, read accepted
      req_valid = 1'b0;
      chk("basic_wr_en", 32'(wr_en), 32'd1);
      chk("basic_wr_address", 32'(wr_address), 32'h0010);
      chk("basic_wr_data", 32'(wr_data), 32'hBEEF);
      tick();
      chk("basic_wr_en_pulse", 32'(wr_en), 32'd0);
      chk("basic_rd_held", 32'(rd_en), 32'd0);
      chk("basic_outstanding1", 32'(outstanding), 32'd1);
      tick();
      chk("basic_rd_held2", 32'(rd_en), 32'd0);
      wr_ret_ack = 1'b1; wr_ret_address = 16'h0010;
      tick();
      wr_ret_ack = 1'b0;
      chk("basic_wr_done", 32'(wr_done), 32'd1);
      chk("basic_wr_done_address", 32'(wr_done_address), 32'h0010);
      chk("basic_rd_held_free_cycle", 32'(rd_en), 32'd0);
      chk("basic_outstanding0", 32'(outstanding), 32'd0);
      tick();
      chk("basic_rd_en", 32'(rd_en), 32'd1);
      chk("basic_rd_address", 32'(rd_address), 32'h0010);
      chk("basic_wr_done_pulse", 32'(wr_done), 32'd0);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0010; rd_ret_data = 16'hBEEF;
      tick();
      rd_ret_ack = 1'b0;
      chk("basic_rd_rsp_valid", 32'(rd_rsp_valid), 32'd1);
      chk("basic_rd_rsp_address", 32'(rd_rsp_address), 32'h0010);
      chk("basic_rd_rsp_data", 32'(rd_rsp_data), 32'hBEEF);
      chk("basic_outstanding_end", 32'(outstanding), 32'd0);
      tick();

      // In-flight limit: five reads, four issue back to back.
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 5) drive_req(1'b0, 16'(i + 1), 16'h0);
         else req_valid = 1'b0;
         tick();
         if (rd_en) cnt++;
      end
      chk("limit_rd_en_count", 32'(cnt), 32'd4);
      chk("limit_outstanding", 32'(outstanding), 32'd4);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0002; rd_ret_data = 16'h2222;
      tick();
      rd_ret_ack = 1'b0;
      chk("limit_rsp_valid", 32'(rd_rsp_valid), 32'd1);
      chk("limit_rsp_address", 32'(rd_rsp_address), 32'h0002);
      chk("limit_outstanding3", 32'(outstanding), 32'd3);
      chk("limit_no_reuse", 32'(rd_en), 32'd0);
      tick();
      chk("limit_fifth_rd_en", 32'(rd_en), 32'd1);
      chk("limit_fifth_address", 32'(rd_address), 32'h0005);
      chk("limit_outstanding4", 32'(outstanding), 32'd4);

      // Full FIFO behind a full table.
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive_req(1'b0, 16'(16'h0100 + i), 16'h0);
         if (req_ready) acc++;
         tick();
      end
      req_valid = 1'b0;
      chk("full_accepted", 32'(acc), 32'(FIFO_DEPTH));
      chk("full_ready_low", 32'(req_ready), 32'd0);

      // Asynchronous reset mid-burst.
      chk("pre_reset_outstanding", 32'(outstanding), 32'd4);
      rst_n = 1'b0;
      #1;
      chk_all_clear("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Unmatched ack with one entry in flight.
      drive_req(1'b0, 16'h0050, 16'h0);
      tick();
      req_valid = 1'b0;
      tick();
      chk("err_outstanding_before", 32'(outstanding), 32'd1);
      chk("err_tag_err_before", 32'(tag_err), 32'd0);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h7777; rd_ret_data = 16'h1111;
      tick();
      rd_ret_ack = 1'b0;
      chk("err_tag_err", 32'(tag_err), 32'd1);
      chk("err_no_rsp", 32'(rd_rsp_valid), 32'd0);
      chk("err_outstanding", 32'(outstanding), 32'd1);
      tick();
      chk("err_sticky", 32'(tag_err), 32'd1);

      // Reset discards in-flight 0x0050; its late ack is unmatched.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_clears_tag_err", 32'(tag_err), 32'd0);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0050;
      tick();
      rd_ret_ack = 1'b0;
      chk("stale_ack_tag_err", 32'(tag_err), 32'd1);
      chk("stale_ack_no_rsp", 32'(rd_rsp_valid), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Simultaneous read ack, write ack and issue.
      drive_req(1'b1, 16'h0020, 16'h1234);
      tick();
      drive_req(1'b0, 16'h0030, 16'h0);
      tick();
      drive_req(1'b0, 16'h0040, 16'h0);
      tick();
      req_valid = 1'b0;
      chk("sim_outstanding_before", 32'(outstanding), 32'd2);
      rd_ret_ack = 1'b1; rd_ret_address = 16'h0030; rd_ret_data = 16'hCAFE;
      wr_ret_ack = 1'b1; wr_ret_address = 16'h0020;
      tick();
      idle();
      chk("sim_rd_rsp_valid", 32'(rd_rsp_valid), 32'd1);
      chk("sim_rd_rsp_data", 32'(rd_rsp_data), 32'hCAFE);
      chk("sim_wr_done", 32'(wr_done), 32'd1);
      chk("sim_wr_done_address", 32'(wr_done_address), 32'h0020);
      chk("sim_rd_en", 32'(rd_en), 32'd1);
      chk("sim_rd_address", 32'(rd_address), 32'h0040);
      chk("sim_outstanding_net", 32'(outstanding), 32'd1);

      // Randomized traffic with a small address set to force hazards.
      for (int i = 0; i < 1500; i++) begin
         idle();
         if (i == 700) begin
            rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 1) == 0)
            drive_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)), 16'($urandom));
         if (inf.size() > 0 && $urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(0, inf.size() - 1));
            if (!inf[k].w || $urandom_range(0, 15) == 0) begin
               rd_ret_ack = 1'b1; rd_ret_address = inf[k].a; rd_ret_data = 16'($urandom);
            end
         end
         if (inf.size() > 0 && $urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(0, inf.size() - 1));
            if (inf[k].w || $urandom_range(0, 15) == 0) begin
               wr_ret_ack = 1'b1; wr_ret_address = inf[k].a;
            end
         end
         tick();
      end
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
